ones_frame_acc: RTL and testbench

Frame-level accumulator placed directly downstream of the parameterized carry-save ones-counter. Each cycle it accepts one per-word ones count (the counter's `{cy, sum}` result) over a valid/ready handshake. It sums the counts across a frame of up to FRAME words and presents a registered frame total with a word tally. A downstream consumer collects the total over a second valid/ready handshake.

---
 rtl/ones_frame_acc.sv | 155 +++++++++++++++
 tb/tb_ones_frame_acc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ones_frame_acc.sv
// ones_frame_acc: sums per-word ones counts into a frame total with a word
// tally, and presents the result to a consumer over a valid/ready handshake.
// Optional threshold compare is enabled by defining ONES_FRAME_ACC_THRESH_EN.
//
// state  | meaning
// -------+----------------------------------------------
// S_IDLE | no words accepted yet, acc/tally are zero
// S_ACC  | at least one word of the frame accepted
// S_HOLD | frame result pending on out_*, input stalled
module ones_frame_acc #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int FRAME = 16,
    parameter int ACC_W = $clog2(DEPTH * FRAME + 1),
    parameter int WC    = $clog2(FRAME + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_cnt,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [WC-1:0]    out_words,
`ifdef ONES_FRAME_ACC_THRESH_EN
    input  logic [ACC_W-1:0] thr,
    output logic             above,
`endif
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WC-1:0]      tally_q, tally_d;
    logic [ACC_W-1:0]   total_q, total_d;
    logic [WC-1:0]      words_q, words_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
`ifdef ONES_FRAME_ACC_THRESH_EN
    logic               above_q, above_d;
`endif

    logic               beat;
    logic               cnt_over;
    logic [CW-1:0]      cnt_clamped;
    logic [ACC_W-1:0]   acc_sum;
    logic [WC-1:0]      tally_inc;
    logic               frame_end;

    // Beat qualification and the arithmetic for the word being accepted.
    always_comb begin
        beat        = in_valid & in_ready_q;
        cnt_over    = (in_cnt > CW'(DEPTH));
        cnt_clamped = cnt_over ? CW'(DEPTH) : in_cnt;
        acc_sum     = acc_q + ACC_W'(cnt_clamped);
        tally_inc   = tally_q + WC'(1);
        frame_end   = (tally_inc == WC'(FRAME)) | in_last;
    end

    // Next-state logic: accumulate, close a frame into the result regs, release on out_ready.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tally_d = tally_q;
        total_d = total_q;
        words_d = words_q;
        err_d   = err_q;
`ifdef ONES_FRAME_ACC_THRESH_EN
        above_d = above_q;
`endif
        case (state_q)
            S_IDLE, S_ACC: begin
                if (beat) begin
                    err_d = err_q | cnt_over;
                    if (frame_end) begin
                        total_d = acc_sum;
                        words_d = tally_inc;
`ifdef ONES_FRAME_ACC_THRESH_EN
                        above_d = (acc_sum >= thr);
`endif
                        acc_d   = '0;
                        tally_d = '0;
                        state_d = S_HOLD;
                    end else begin
                        acc_d   = acc_sum;
                        tally_d = tally_inc;
                        state_d = S_ACC;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                acc_d   = '0;
                tally_d = '0;
            end
        endcase
        // Handshake flags are registered from the next state so neither has a
        // combinational path from out_ready or in_valid.
        in_ready_d  = (state_d != S_HOLD);
        out_valid_d = (state_d == S_HOLD);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            tally_q     <= '0;
            total_q     <= '0;
            words_q     <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ONES_FRAME_ACC_THRESH_EN
            above_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tally_q     <= tally_d;
            total_q     <= total_d;
            words_q     <= words_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef ONES_FRAME_ACC_THRESH_EN
            above_q     <= above_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_total = total_q;
    assign out_words = words_q;
    assign err       = err_q;
`ifdef ONES_FRAME_ACC_THRESH_EN
    assign above     = above_q;
`endif

endmodule

// File: tb/tb_ones_frame_acc.sv
// Testbench for ones_frame_acc: directed scenarios followed by random traffic,
// all checked cycle by cycle against a frame-level reference model.
module tb_ones_frame_acc;

    localparam int DEPTH = 8;
    localparam int FRAME = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int ACC_W = $clog2(DEPTH * FRAME + 1);
    localparam int WC    = $clog2(FRAME + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    in_cnt;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_total;
    logic [WC-1:0]    out_words;
    logic             err;
    logic [ACC_W-1:0] thr_v;
`ifdef ONES_FRAME_ACC_THRESH_EN
    logic             above;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: words of the open frame and the pending result.
    int m_cur[$];
    bit m_pending;
    int m_total;
    int m_words;
    bit m_above;
    bit m_err;

    ones_frame_acc #(.DEPTH(DEPTH), .FRAME(FRAME)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cnt    (in_cnt),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_total (out_total),
        .out_words (out_words),
`ifdef ONES_FRAME_ACC_THRESH_EN
        .thr       (thr_v),
        .above     (above),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model, then drive one cycle of stimulus
    // and advance the model by what that cycle's edge should do.
    task automatic cyc(input bit v, input int cnt, input bit last, input bit ordy);
        int s;
        chk("in_ready", int'(in_ready), int'(!m_pending));
        chk("out_valid", int'(out_valid), int'(m_pending));
        chk("err", int'(err), int'(m_err));
        if (m_pending) begin
            chk("out_total", int'(out_total), m_total);
            chk("out_words", int'(out_words), m_words);
`ifdef ONES_FRAME_ACC_THRESH_EN
            chk("above", int'(above), int'(m_above));
`endif
        end
        in_valid  = v;
        in_cnt    = CW'(cnt);
        in_last   = last;
        out_ready = ordy;
        if (m_pending) begin
            if (ordy) m_pending = 1'b0;
        end else if (v) begin
            if (cnt > DEPTH) m_err = 1'b1;
            m_cur.push_back(cnt > DEPTH ? DEPTH : cnt);
            if (m_cur.size() == FRAME || last) begin
                s = 0;
                foreach (m_cur[i]) s += m_cur[i];
                m_total   = s;
                m_words   = m_cur.size();
                m_above   = (s >= int'(thr_v));
                m_pending = 1'b1;
                m_cur.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_cnt    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        m_cur.delete();
        m_pending = 1'b0;
        m_err     = 1'b0;
        m_above   = 1'b0;
        chk("rst_out_total", int'(out_total), 0);
        chk("rst_out_words", int'(out_words), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_err", int'(err), 0);
`ifdef ONES_FRAME_ACC_THRESH_EN
        chk("rst_above", int'(above), 0);
`endif
    endtask

    initial begin
        int c;
        thr_v = ACC_W'(16);
        do_reset();

        // Full frame with consumer always ready.
        cyc(1, 3, 0, 1); cyc(1, 8, 0, 1); cyc(1, 0, 0, 1); cyc(1, 5, 0, 1);
        chk("tp1_valid", int'(out_valid), 1);
        chk("tp1_total", int'(out_total), 16);
        chk("tp1_words", int'(out_words), 4);
        chk("tp1_err", int'(err), 0);
        cyc(0, 0, 0, 1);
        chk("tp1_valid_drop", int'(out_valid), 0);

        // Short frame closed by in_last, then a 1-word frame.
        cyc(1, 2, 0, 1); cyc(1, 7, 1, 1);
        chk("tp2_total", int'(out_total), 9);
        chk("tp2_words", int'(out_words), 2);
        cyc(0, 0, 0, 1);
        cyc(1, 1, 1, 1);
        chk("tp2_single_total", int'(out_total), 1);
        chk("tp2_single_words", int'(out_words), 1);
        cyc(0, 0, 0, 1);

        // Consumer stall with a held upstream word.
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("tp3_hold_ready", int'(in_ready), 0);
            chk("tp3_hold_total", int'(out_total), 4);
            cyc(1, 2, 0, 0);
        end
        cyc(1, 2, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 2, 0, 1);
        chk("tp3_next_total", int'(out_total), 8);
        chk("tp3_next_words", int'(out_words), 4);
        cyc(0, 0, 0, 1);

        // Out-of-range count is clamped and latches err.
        cyc(1, 9, 0, 1); cyc(1, 1, 0, 1); cyc(1, 1, 0, 1); cyc(1, 1, 0, 1);
        chk("tp4_total", int'(out_total), 11);
        chk("tp4_err", int'(err), 1);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1);
        cyc(0, 0, 0, 1);
        chk("tp4_err_sticky", int'(err), 1);

        // Reset in the middle of a frame discards it.
        do_reset();
        cyc(1, 4, 0, 1); cyc(1, 4, 0, 1);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1);
        chk("tp5_total", int'(out_total), 4);
        chk("tp5_words", int'(out_words), 4);
        cyc(0, 0, 0, 1);

`ifdef ONES_FRAME_ACC_THRESH_EN
        thr_v = ACC_W'(16);
        cyc(1, 8, 0, 1); cyc(1, 8, 0, 1); cyc(1, 0, 0, 1); cyc(1, 0, 0, 1);
        chk("thr_above_hi", int'(above), 1);
        cyc(0, 0, 0, 1);
        cyc(1, 8, 0, 1); cyc(1, 7, 0, 1); cyc(1, 0, 0, 1); cyc(1, 0, 0, 1);
        chk("thr_above_lo", int'(above), 0);
        cyc(0, 0, 0, 1);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 19) == 0) ? int'($urandom_range(9, 15))
                                             : int'($urandom_range(0, DEPTH));
            thr_v = ACC_W'($urandom_range(0, DEPTH * FRAME));
            cyc(bit'($urandom_range(0, 3) != 0), c,
                bit'($urandom_range(0, 3) == 0),
                bit'($urandom_range(0, 2) != 0));
        end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
